seq_enc_8_3: RTL and testbench

Sequential 8:3 encoder; the inverse of the team's 3:8 one-hot decoder. Accepts a multi-hot 8-bit request vector through a valid/ready handshake. Emits the 3-bit index of every set bit, one index per output handshake, in priority order. Used wherever decoded select/request lines must be re-encoded and serialised back to binary codes (e.g. interrupt or grant collection).

---
 rtl/seq_enc_pkg.sv | 15 +
 rtl/prio_enc_8_3.sv | 36 +++
 rtl/seq_enc_8_3.sv | 97 +++++++++
 tb/tb_seq_enc_8_3.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_enc_pkg.sv
// Shared types and sizes for the sequential 8:3 encoder.
package seq_enc_pkg;

  localparam int N  = 8;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [IW-1:0] idx_t;

endpackage

// File: rtl/prio_enc_8_3.sv
// Combinational 8:3 priority encoder used to pick the next index to emit.
// Optional macro SEQ_ENC_MSB_FIRST_EN: highest set bit wins instead of lowest.
// An all-zero vector encodes to index 0 with any=0.
module prio_enc_8_3
  import seq_enc_pkg::*;
(
  input  logic [N-1:0] vec,
  output idx_t         idx,
  output logic         any,
  output logic         one
);

  logic [N-1:0] vec_m1;

  // Scan so that the highest-priority set bit is the last one written.
  always_comb begin
    idx = '0;
`ifdef SEQ_ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = IW'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
`endif
  end

  // Exactly one bit set: nonzero and clearing the lowest bit leaves nothing.
  always_comb begin
    vec_m1 = vec - N'(1);
    any    = |vec;
    one    = any && ((vec & vec_m1) == '0);
  end

endmodule

// File: rtl/seq_enc_8_3.sv
// Sequential 8:3 encoder: accepts a multi-hot vector, emits one index per
// output handshake in priority order, then pulses done.
// Optional macro SEQ_ENC_MSB_FIRST_EN reverses the scan order (MSB first).
//
// state | meaning
// IDLE  | ready for a new vector (once out of reset)
// EMIT  | presenting the priority index of the remaining bits
// DONE  | one-cycle done pulse, input still blocked
module seq_enc_8_3
  import seq_enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_vec,
  output logic         in_ready,
  output logic         out_valid,
  output logic [IW-1:0] out_idx,
  output logic         out_last,
  input  logic         out_ready,
  output logic         done
);

  state_t       state_q, state_d;
  logic [N-1:0] rem_q, rem_d;
  logic         started_q;
  logic [N-1:0] clr_mask;
  idx_t         pe_idx;
  logic         pe_any;
  logic         pe_one;

  prio_enc_8_3 u_prio (
    .vec (rem_q),
    .idx (pe_idx),
    .any (pe_any),
    .one (pe_one)
  );

  // started_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      started_q <= 1'b1;
    end
  end

  // Next-state, remaining-vector update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    clr_mask  = '0;
    clr_mask[pe_idx] = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = started_q;
        if (in_valid && started_q) begin
          if (in_vec != '0) begin
            rem_d   = in_vec;
            state_d = EMIT;
          end else begin
            state_d = DONE;
          end
        end
      end
      EMIT: begin
        out_valid = pe_any;
        if (pe_any && out_ready) begin
          rem_d = rem_q & ~clr_mask;
          if (pe_one) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Index is driven straight from rem; rem is empty outside EMIT so it reads 0.
  always_comb begin
    out_idx  = pe_idx;
    out_last = (state_q == EMIT) && pe_one;
  end

endmodule

// File: tb/tb_seq_enc_8_3.sv
// Self-checking bench for seq_enc_8_3: vector table, hand-written corner
// sequences and randomized vectors against a queue-based reference model.
module tb_seq_enc_8_3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_ready;
  logic       done;

  int total = 0;
  int bad   = 0;

  seq_enc_8_3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ready (out_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vec;
    int         mode;      // 0: ready=1, 1: ready toggles 1,0,..., 2: random
    int         beats;
    int         lsb_first; // first/last index in LSB-first order
    int         lsb_last;
  } vec_rec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: ordered list of set-bit positions.
  function automatic void model(input logic [7:0] v, output int q[$]);
    q = {};
`ifdef SEQ_ENC_MSB_FIRST_EN
    for (int k = 7; k >= 0; k--) if (v[k]) q.push_back(k);
`else
    for (int k = 0; k < 8; k++) if (v[k]) q.push_back(k);
`endif
  endfunction

  task automatic run_vec(input logic [7:0] v, input int mode,
                         output int nbeats, output int first_idx, output int last_idx);
    int   q[$];
    int   n;
    bit   prev_stall, last_acc, finished;
    int   prev_idx, prev_last;
    model(v, q);
    nbeats = 0; first_idx = -1; last_idx = -1;
    prev_stall = 0; last_acc = 0; finished = 0; prev_idx = 0; prev_last = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = v;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = 8'($urandom);
    for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
      @(negedge clk);
      chk("done", int'(done), int'((cyc == 0 && q.size() == 0) || last_acc));
      if (done) begin
        chk("beat_count", nbeats, q.size());
        chk("out_valid_in_done", int'(out_valid), 0);
        if (mode == 0) chk("cycles_to_done", cyc, q.size());
        finished = 1;
      end else begin
        chk("out_valid", int'(out_valid), int'(nbeats < q.size()));
        if (out_valid) begin
          if (nbeats < q.size()) chk("out_idx", int'(out_idx), q[nbeats]);
          chk("out_last", int'(out_last), int'(nbeats == q.size() - 1));
          if (prev_stall) begin
            chk("hold_idx", int'(out_idx), prev_idx);
            chk("hold_last", int'(out_last), prev_last);
          end
          if (nbeats == 0) first_idx = int'(out_idx);
          last_idx = int'(out_idx);
        end
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc % 2 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        prev_stall = out_valid && !out_ready;
        prev_idx   = int'(out_idx);
        prev_last  = int'(out_last);
        last_acc   = out_valid && out_ready && out_last;
        if (out_valid && out_ready) nbeats++;
      end
    end
    if (!finished) begin
      chk("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("in_ready_after_done", int'(in_ready), 1);
      chk("out_valid_idle", int'(out_valid), 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  int'(in_ready),  0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_idx"},   int'(out_idx),   0);
    chk({tag, "_out_last"},  int'(out_last),  0);
    chk({tag, "_done"},      int'(done),      0);
  endtask

  vec_rec_t tbl[$];

  initial begin
    int nb, fi, li, ef, el, n;
    logic [7:0] rv, dec;

    tbl.push_back('{vec: 8'b1010_0100, mode: 0, beats: 3, lsb_first: 2, lsb_last: 7});
    tbl.push_back('{vec: 8'h00,        mode: 0, beats: 0, lsb_first: 0, lsb_last: 0});
    tbl.push_back('{vec: 8'hFF,        mode: 1, beats: 8, lsb_first: 0, lsb_last: 7});
    tbl.push_back('{vec: 8'b0001_0011, mode: 0, beats: 3, lsb_first: 0, lsb_last: 4});
    tbl.push_back('{vec: 8'h81,        mode: 2, beats: 2, lsb_first: 0, lsb_last: 7});
    tbl.push_back('{vec: 8'h3C,        mode: 1, beats: 4, lsb_first: 2, lsb_last: 5});
    for (int c = 0; c < 8; c++)
      tbl.push_back('{vec: 8'(1 << c), mode: 0, beats: 1, lsb_first: c, lsb_last: c});

    rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
    #3;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_before_first_edge", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_first_edge", int'(in_ready), 1);

    foreach (tbl[i]) begin
      run_vec(tbl[i].vec, tbl[i].mode, nb, fi, li);
`ifdef SEQ_ENC_MSB_FIRST_EN
      ef = tbl[i].lsb_last;  el = tbl[i].lsb_first;
`else
      ef = tbl[i].lsb_first; el = tbl[i].lsb_last;
`endif
      chk($sformatf("tbl%0d_beats", i), nb, tbl[i].beats);
      if (tbl[i].beats > 0) begin
        chk($sformatf("tbl%0d_first", i), fi, ef);
        chk($sformatf("tbl%0d_last", i), li, el);
      end
      if (tbl[i].beats == 1) begin
        dec = 8'(1 << fi);
        chk($sformatf("tbl%0d_roundtrip", i), int'(dec), int'(tbl[i].vec));
      end
    end

    // Reset in the middle of 8'h81 after its first beat.
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'h81; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_seq_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_vec = 8'h5A;
    @(negedge clk);
    chk("rst_seq_valid", int'(out_valid), 1);
`ifdef SEQ_ENC_MSB_FIRST_EN
    chk("rst_seq_first_idx", int'(out_idx), 7);
`else
    chk("rst_seq_first_idx", int'(out_idx), 0);
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_no_done", int'(done), 0);
      chk("mid_rst_no_valid", int'(out_valid), 0);
    end
    rst = 1'b0;
    #1;
    chk("mid_in_ready_after_release", int'(in_ready), 0);
    run_vec(8'h10, 0, nb, fi, li);
    chk("post_rst_beats", nb, 1);
    chk("post_rst_idx", fi, 4);

    // Randomized vectors with random backpressure; model checks inside run_vec.
    for (int r = 0; r < 40; r++) begin
      rv = 8'($urandom);
      if (r % 10 == 0) rv = 8'h00;
      run_vec(rv, 2, nb, fi, li);
      chk("rand_beats", nb, $countones(rv));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
